// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised valid/ready pipeline stage with optional 2-entry skid buffer,
// flush-keep mask and saturating stall counter.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   clr        synchronous flush (bubble insert)
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts the beat this cycle
//   out_data   payload of head entry (registered)
//   occupancy  entries held: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
module pipe_stage_buf #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] KEEP_MASK = '0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit                SKID      = 1'b1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;
    state_t            state, state_n;
    logic [DATA_W-1:0] main_q, main_n, skid_q, skid_n;
    logic              rdy_q;
    logic              in_fire, out_fire;
    // SKID=1 keeps in_ready registered to cut the out_ready -> in_ready path.
    assign in_ready  = SKID ? rdy_q : (state == EMPTY) || out_ready;
    assign out_valid = state != EMPTY;
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (clr) begin
            state_n = EMPTY;
            main_n  = (in_data & KEEP_MASK) | (RESET_VAL & ~KEEP_MASK);
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_n = HALF;
                    main_n  = in_data;
                end
                HALF: if (in_fire && out_fire) begin
                    main_n = in_data;
                end else if (in_fire) begin
                    state_n = FULL;
                    skid_n  = in_data;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end
                FULL: if (out_fire) begin
                    state_n = HALF;
                    main_n  = skid_q;
                end
                default: state_n = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_q    <= RESET_VAL;
            skid_q    <= '0;
            rdy_q     <= 1'b1;
            stall_cnt <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
            rdy_q  <= state_n != FULL;
            if (out_valid && !out_ready && !clr && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed bench for pipe_stage_buf with a queue-based reference model.
module tb_pipe_stage_buf;
    localparam logic [31:0] A_KM = 32'hFFFF0000;
    localparam logic [31:0] A_RV = 32'hCAFE0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_clr = 1'b0, a_v = 1'b0, a_rdy_o = 1'b0;
    logic [31:0] a_d = '0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;

    logic        b_rst = 1'b1, b_clr = 1'b0, b_v = 1'b0, b_rdy_o = 1'b0;
    logic [7:0]  b_d = '0;
    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall;

    pipe_stage_buf #(.DATA_W(32), .KEEP_MASK(A_KM), .RESET_VAL(A_RV), .SKID(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(a_rst), .clr(a_clr), .in_valid(a_v), .in_ready(a_in_ready),
        .in_data(a_d), .out_valid(a_out_valid), .out_ready(a_rdy_o), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall));

    pipe_stage_buf #(.DATA_W(8), .SKID(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(b_rst), .clr(b_clr), .in_valid(b_v), .in_ready(b_in_ready),
        .in_data(b_d), .out_valid(b_out_valid), .out_ready(b_rdy_o), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall));

    int checks = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of beats in flight plus the last payload seen at the head.
    logic [31:0] qa[$];
    logic [31:0] la = A_RV;
    int          ca = 0;
    bit          a_inf, a_outf;
    always @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            qa.delete();
            la = A_RV;
            ca = 0;
        end else begin
            a_outf = qa.size() > 0 && a_rdy_o;
            a_inf  = a_v && qa.size() < 2;
            if (qa.size() > 0 && !a_rdy_o && !a_clr && ca < 65535) ca++;
            if (a_clr) begin
                qa.delete();
                la = (a_d & A_KM) | (A_RV & ~A_KM);
            end else begin
                if (a_outf) la = qa.pop_front();
                if (a_inf) qa.push_back(a_d);
                if (qa.size() > 0) la = qa[0];
            end
        end
    end

    logic [7:0] qb[$];
    logic [7:0] lb = '0;
    int         cb = 0;
    bit         b_inf, b_outf;
    always @(posedge clk or posedge b_rst) begin
        if (b_rst) begin
            qb.delete();
            lb = '0;
            cb = 0;
        end else begin
            b_outf = qb.size() > 0 && b_rdy_o;
            b_inf  = b_v && (qb.size() == 0 || b_rdy_o);
            if (qb.size() > 0 && !b_rdy_o && !b_clr && cb < 15) cb++;
            if (b_clr) begin
                qb.delete();
                lb = '0;
            end else begin
                if (b_outf) lb = qb.pop_front();
                if (b_inf) qb.push_back(b_d);
                if (qb.size() > 0) lb = qb[0];
            end
        end
    end

    always @(negedge clk) begin
        chk("a_out_valid", a_out_valid, qa.size() > 0);
        chk("a_out_data", a_out_data, la);
        chk("a_in_ready", a_in_ready, qa.size() < 2);
        chk("a_occupancy", a_occ, qa.size());
        chk("a_stall_cnt", a_stall, ca);
        chk("b_out_valid", b_out_valid, qb.size() > 0);
        chk("b_out_data", b_out_data, lb);
        chk("b_in_ready", b_in_ready, qb.size() == 0 || b_rdy_o);
        chk("b_occupancy", b_occ, qb.size());
        chk("b_stall_cnt", b_stall, cb);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        chk("reset_a_data", a_out_data, 32'hCAFE0000);
        chk("reset_a_ready", a_in_ready, 1'b1);
        chk("reset_a_valid", a_out_valid, 1'b0);

        // T1: back-to-back stream
        a_rdy_o = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_v = 1'b1;
            a_d = i;
            step();
            chk("t1_data", a_out_data, i);
            chk("t1_ready", a_in_ready, 1'b1);
        end
        a_v = 1'b0;
        step();
        chk("t1_stall", a_stall, 16'd0);
        chk("t1_empty", a_out_valid, 1'b0);

        // T2: backpressure fills the skid, then drains in order
        a_rdy_o = 1'b0;
        a_v = 1'b1;
        a_d = 32'h11;
        step();
        a_d = 32'h22;
        step();
        a_d = 32'h33;
        step();
        chk("t2_occ", a_occ, 2'd2);
        chk("t2_ready", a_in_ready, 1'b0);
        chk("t2_head", a_out_data, 32'h11);
        chk("t2_stall", a_stall, 16'd2);
        a_rdy_o = 1'b1;
        step();
        chk("t2_d22", a_out_data, 32'h22);
        chk("t2_ready_back", a_in_ready, 1'b1);
        step();
        chk("t2_d33", a_out_data, 32'h33);
        chk("t2_occ1", a_occ, 2'd1);
        a_v = 1'b0;
        step();
        chk("t2_drained", a_out_valid, 1'b0);
        chk("t2_stall_end", a_stall, 16'd2);

        // T3: flush a full stage with a partial keep mask
        a_rdy_o = 1'b0;
        a_v = 1'b1;
        a_d = 32'hAAAA1111;
        step();
        a_d = 32'hBBBB2222;
        step();
        chk("t3_full", a_occ, 2'd2);
        a_clr = 1'b1;
        a_d = 32'h12345678;
        step();
        a_clr = 1'b0;
        a_v = 1'b0;
        chk("t3_valid", a_out_valid, 1'b0);
        chk("t3_occ", a_occ, 2'd0);
        chk("t3_data", a_out_data, 32'h12340000);
        chk("t3_stall", a_stall, 16'd3);
        a_rdy_o = 1'b1;
        repeat (3) begin
            step();
            chk("t3_no_skid", a_out_valid, 1'b0);
        end

        // T4: asynchronous reset while full
        a_rdy_o = 1'b0;
        a_v = 1'b1;
        a_d = 32'h1;
        step();
        a_d = 32'h2;
        step();
        a_v = 1'b0;
        chk("t4_full", a_occ, 2'd2);
        #2 a_rst = 1'b1;
        #1;
        chk("t4_valid", a_out_valid, 1'b0);
        chk("t4_data", a_out_data, 32'hCAFE0000);
        chk("t4_ready", a_in_ready, 1'b1);
        chk("t4_occ", a_occ, 2'd0);
        chk("t4_stall", a_stall, 16'd0);
        step();
        a_rst = 1'b0;
        step();
        chk("t4_after", a_out_valid, 1'b0);

        // T5: single-entry stage, combinational in_ready
        b_rdy_o = 1'b0;
        b_v = 1'b1;
        b_d = 8'h5A;
        step();
        chk("t5_held", b_out_data, 8'h5A);
        chk("t5_ready0", b_in_ready, 1'b0);
        b_d = 8'hA5;
        b_rdy_o = 1'b1;
        #1;
        chk("t5_ready1", b_in_ready, 1'b1);
        step();
        chk("t5_data", b_out_data, 8'hA5);
        chk("t5_valid", b_out_valid, 1'b1);
        chk("t5_stall", b_stall, 4'd0);

        // T6: stall counter saturation
        b_v = 1'b0;
        b_rdy_o = 1'b0;
        repeat (20) step();
        chk("t6_sat", b_stall, 4'd15);
        repeat (2) step();
        chk("t6_hold", b_stall, 4'd15);
        chk("t6_valid", b_out_valid, 1'b1);
        b_rdy_o = 1'b1;
        step();
        chk("t6_drain", b_out_valid, 1'b0);
        chk("t6_kept", b_stall, 4'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
